hdlc_rx_protocol_checker: RTL and testbench

//  Synthesizable, parametrised runtime protocol checker for N_CH HDLC receive channels.

---
 rtl/hdlc_rx_protocol_checker_if.sv | 26 ++
 rtl/hdlc_rx_protocol_checker.sv | 184 ++++++++++++++++++
 tb/tb_hdlc_rx_protocol_checker.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdlc_rx_protocol_checker_if.sv
// Bus bundle between the monitored HDLC Rx path and the protocol checker.
// The master side drives line/receiver indications; the slave (checker) reports errors and counts.
interface hdlc_rx_protocol_checker_if #(
  parameter int unsigned N_CH  = 1,
  parameter int unsigned CNT_W = 16
);
  logic [N_CH-1:0]  Rx;
  logic [N_CH-1:0]  Rx_FlagDetect;
  logic [N_CH-1:0]  Rx_ValidFrame;
  logic [N_CH-1:0]  Rx_AbortSignal;
  logic [N_CH-1:0]  FlagErr;
  logic [N_CH-1:0]  SpuriousFlag;
  logic [N_CH-1:0]  AbortErr;
  logic [CNT_W-1:0] ErrCnt;
  logic [CNT_W-1:0] FlagCnt;

  modport master (
    output Rx, Rx_FlagDetect, Rx_ValidFrame, Rx_AbortSignal,
    input  FlagErr, SpuriousFlag, AbortErr, ErrCnt, FlagCnt
  );

  modport slave (
    input  Rx, Rx_FlagDetect, Rx_ValidFrame, Rx_AbortSignal,
    output FlagErr, SpuriousFlag, AbortErr, ErrCnt, FlagCnt
  );
endinterface

// File: rtl/hdlc_rx_protocol_checker.sv
// Runtime checker for N_CH HDLC Rx channels: snoops each line for flags/aborts and verifies
// the receiver's flag/abort indications against fixed latencies, with saturating counters.
module hdlc_rx_protocol_checker #(
  parameter int unsigned N_CH       = 1,
  parameter int unsigned FLAG_LAT   = 2,
  parameter int unsigned ABORT_LAT  = 1,
  parameter int unsigned ABORT_ONES = 7,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      Enable,
  input  logic                      ClearCnt,
  hdlc_rx_protocol_checker_if.slave bus
);

  localparam int unsigned ONES_W = $clog2(ABORT_ONES + 1);
  localparam int unsigned TMR_W  = $clog2(ABORT_LAT + 1);
  localparam int unsigned POP_W  = $clog2(N_CH + 1);
  localparam int unsigned SUM_W  = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [7:0] FLAG_PAT = 8'b0111_1110;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_SYNC,
    ST_RUN
  } state_e;

  logic [N_CH-1:0] err_set_c;
  logic [N_CH-1:0] hit_vec_c;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_e              state_q, state_d;
    logic [7:0]          sh_q, sh_d;
    logic [2:0]          bits_q, bits_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic [FLAG_LAT-1:0] pipe_q, pipe_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                ferr_q, ferr_d;
    logic                spur_q, spur_d;
    logic                aerr_q, aerr_d;
    logic                hit_c, mature_c;
    logic                rx_c, fd_c, vf_c, ab_c;

    assign rx_c = bus.Rx[g];
    assign fd_c = bus.Rx_FlagDetect[g];
    assign vf_c = bus.Rx_ValidFrame[g];
    assign ab_c = bus.Rx_AbortSignal[g];

    // Channel state, history and pending-check registers
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        state_q <= ST_OFF;
        sh_q    <= '0;
        bits_q  <= '0;
        ones_q  <= '0;
        pipe_q  <= '0;
        tmr_q   <= '0;
        ferr_q  <= 1'b0;
        spur_q  <= 1'b0;
        aerr_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        sh_q    <= sh_d;
        bits_q  <= bits_d;
        ones_q  <= ones_d;
        pipe_q  <= pipe_d;
        tmr_q   <= tmr_d;
        ferr_q  <= ferr_d;
        spur_q  <= spur_d;
        aerr_q  <= aerr_d;
      end
    end

    // Next state, sampling, flag/abort detection and check evaluation
    always_comb begin
      state_d  = state_q;
      sh_d     = sh_q;
      bits_d   = bits_q;
      ones_d   = ones_q;
      pipe_d   = pipe_q;
      tmr_d    = tmr_q;
      ferr_d   = 1'b0;
      spur_d   = 1'b0;
      aerr_d   = 1'b0;
      hit_c    = 1'b0;
      mature_c = 1'b0;

      if (!Enable) begin
        state_d = ST_OFF;
        sh_d    = '0;
        bits_d  = '0;
        ones_d  = '0;
        pipe_d  = '0;
        tmr_d   = '0;
      end else begin
        case (state_q)
          ST_OFF:  state_d = ST_SYNC;
          ST_SYNC: begin
            if (bits_q == 3'd7) state_d = ST_RUN;
            bits_d = bits_q + 3'd1;
          end
          ST_RUN:  state_d = ST_RUN;
          default: state_d = ST_OFF;
        endcase

        if (state_q != ST_OFF) begin
          sh_d     = {sh_q[6:0], rx_c};
          hit_c    = (sh_d == FLAG_PAT) && ((state_q == ST_RUN) || (bits_q == 3'd7));
          mature_c = pipe_q[FLAG_LAT-1];
          pipe_d   = (pipe_q << 1) | FLAG_LAT'(hit_c);
          ferr_d   = mature_c && !fd_c;
          spur_d   = !mature_c && fd_c && (state_q == ST_RUN);

          // Abort window: any receiver indication inside the window satisfies it
          if (tmr_q != '0) begin
            if (ab_c) begin
              tmr_d = '0;
            end else if (tmr_q == TMR_W'(1)) begin
              aerr_d = 1'b1;
              tmr_d  = '0;
            end else begin
              tmr_d = tmr_q - TMR_W'(1);
            end
          end

          if (rx_c) begin
            if (ones_q != ONES_W'(ABORT_ONES)) ones_d = ones_q + ONES_W'(1);
            if ((ones_q == ONES_W'(ABORT_ONES - 1)) && vf_c) tmr_d = TMR_W'(ABORT_LAT);
          end else begin
            ones_d = '0;
          end
        end
      end
    end

    assign err_set_c[g]        = ferr_d | spur_d | aerr_d;
    assign hit_vec_c[g]        = hit_c;
    assign bus.FlagErr[g]      = ferr_q;
    assign bus.SpuriousFlag[g] = spur_q;
    assign bus.AbortErr[g]     = aerr_q;
  end

  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] flag_cnt_q, flag_cnt_d;
  logic [POP_W-1:0] err_pop_c, flag_pop_c;
  logic [SUM_W-1:0] err_sum_c, flag_sum_c;

  // Saturating totals; a same-edge clear discards that edge's increments
  always_comb begin
    err_pop_c  = '0;
    flag_pop_c = '0;
    for (int i = 0; i < N_CH; i++) begin
      err_pop_c  = err_pop_c + POP_W'(err_set_c[i]);
      flag_pop_c = flag_pop_c + POP_W'(hit_vec_c[i]);
    end
    err_sum_c  = SUM_W'(err_cnt_q) + SUM_W'(err_pop_c);
    flag_sum_c = SUM_W'(flag_cnt_q) + SUM_W'(flag_pop_c);
    err_cnt_d  = err_cnt_q;
    flag_cnt_d = flag_cnt_q;
    if (ClearCnt) begin
      err_cnt_d  = '0;
      flag_cnt_d = '0;
    end else if (Enable) begin
      err_cnt_d  = (err_sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : err_sum_c[CNT_W-1:0];
      flag_cnt_d = (flag_sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : flag_sum_c[CNT_W-1:0];
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      err_cnt_q  <= '0;
      flag_cnt_q <= '0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      flag_cnt_q <= flag_cnt_d;
    end
  end

  assign bus.ErrCnt  = err_cnt_q;
  assign bus.FlagCnt = flag_cnt_q;

endmodule

// File: tb/tb_hdlc_rx_protocol_checker.sv
// Bench for hdlc_rx_protocol_checker: directed scenarios plus random traffic checked
// against a sample-history reference model; a 1-channel 2-bit-counter copy covers saturation.
module tb_hdlc_rx_protocol_checker;

  localparam int NCH  = 4;
  localparam int FLAT = 2;
  localparam int ALAT = 1;
  localparam int ONES = 7;

  logic clk;
  logic rst;
  logic enable;
  logic clear_cnt;

  hdlc_rx_protocol_checker_if #(.N_CH(NCH), .CNT_W(16)) bus_a ();
  hdlc_rx_protocol_checker_if #(.N_CH(1),   .CNT_W(2))  bus_b ();

  assign bus_b.Rx             = bus_a.Rx[0:0];
  assign bus_b.Rx_FlagDetect  = bus_a.Rx_FlagDetect[0:0];
  assign bus_b.Rx_ValidFrame  = bus_a.Rx_ValidFrame[0:0];
  assign bus_b.Rx_AbortSignal = bus_a.Rx_AbortSignal[0:0];

  hdlc_rx_protocol_checker #(
    .N_CH(NCH), .FLAG_LAT(FLAT), .ABORT_LAT(ALAT), .ABORT_ONES(ONES), .CNT_W(16)
  ) u_dut_a (
    .Clk(clk), .Rst(rst), .Enable(enable), .ClearCnt(clear_cnt), .bus(bus_a.slave)
  );

  hdlc_rx_protocol_checker #(
    .N_CH(1), .FLAG_LAT(FLAT), .ABORT_LAT(ALAT), .ABORT_ONES(ONES), .CNT_W(2)
  ) u_dut_b (
    .Clk(clk), .Rst(rst), .Enable(enable), .ClearCnt(clear_cnt), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: raw sample history, list of due cycles for flag checks, abort deadline.
  int cyc = 0;
  bit live [NCH];
  bit hist [NCH][$];
  int ones [NCH];
  int due  [NCH][$];
  int abort_dl [NCH];
  bit pat [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
  logic [NCH-1:0] e_ferr, e_spur, e_aerr;
  int e_err, e_flag, e_err2, e_flag2;
  bit src [NCH][$];

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      live[ch] = 0; hist[ch].delete(); ones[ch] = 0; due[ch].delete(); abort_dl[ch] = -1;
    end
    e_ferr = '0; e_spur = '0; e_aerr = '0;
    e_err = 0; e_flag = 0; e_err2 = 0; e_flag2 = 0;
  endtask

  task automatic model_update();
    int pe, pf, pe0, pf0;
    pe = 0; pf = 0; pe0 = 0; pf0 = 0;
    e_ferr = '0; e_spur = '0; e_aerr = '0;
    cyc++;
    if (!enable) begin
      for (int ch = 0; ch < NCH; ch++) begin
        live[ch] = 0; hist[ch].delete(); ones[ch] = 0; due[ch].delete(); abort_dl[ch] = -1;
      end
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        bit r, hit, mat, running;
        if (!live[ch]) begin
          live[ch] = 1;
        end else begin
          r = bus_a.Rx[ch];
          running = (hist[ch].size() == 8);
          mat = (due[ch].size() > 0) && (due[ch][0] == cyc);
          if (mat) void'(due[ch].pop_front());
          if (mat && !bus_a.Rx_FlagDetect[ch]) e_ferr[ch] = 1'b1;
          if (!mat && running && bus_a.Rx_FlagDetect[ch]) e_spur[ch] = 1'b1;
          if (abort_dl[ch] >= 0) begin
            if (bus_a.Rx_AbortSignal[ch]) abort_dl[ch] = -1;
            else if (abort_dl[ch] == cyc) begin e_aerr[ch] = 1'b1; abort_dl[ch] = -1; end
          end
          hist[ch].push_back(r);
          if (hist[ch].size() > 8) void'(hist[ch].pop_front());
          if (r) begin
            if (ones[ch] == ONES - 1 && bus_a.Rx_ValidFrame[ch]) abort_dl[ch] = cyc + ALAT;
            if (ones[ch] < ONES) ones[ch]++;
          end else begin
            ones[ch] = 0;
          end
          hit = (hist[ch].size() == 8);
          for (int i = 0; i < 8; i++) if (hit && hist[ch][i] != pat[i]) hit = 0;
          if (hit) begin
            pf++; due[ch].push_back(cyc + FLAT);
            if (ch == 0) pf0++;
          end
          if (e_ferr[ch] | e_spur[ch] | e_aerr[ch]) begin
            pe++;
            if (ch == 0) pe0++;
          end
        end
      end
    end
    if (clear_cnt) begin
      e_err = 0; e_flag = 0; e_err2 = 0; e_flag2 = 0;
    end else begin
      e_err = sat(e_err + pe, 65535);  e_flag = sat(e_flag + pf, 65535);
      e_err2 = sat(e_err2 + pe0, 3);   e_flag2 = sat(e_flag2 + pf0, 3);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus_a.Rx = '1; bus_a.Rx_FlagDetect = '0; bus_a.Rx_ValidFrame = '0; bus_a.Rx_AbortSignal = '0;
    clear_cnt = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    enable = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b1;
  endtask

  task automatic go_run();
    idle_inputs();
    enable = 1'b1;
    repeat (10) tick();
  endtask

  task automatic send_flag(input logic [NCH-1:0] mask);
    logic [7:0] fl;
    fl = 8'h7E;
    for (int i = 0; i < 8; i++) begin
      for (int ch = 0; ch < NCH; ch++) bus_a.Rx[ch] = mask[ch] ? fl[7-i] : 1'b1;
      tick();
    end
    bus_a.Rx = '1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus_a.FlagErr !== 4'h0 || bus_a.SpuriousFlag !== 4'h0 || bus_a.AbortErr !== 4'h0) begin
      errors++; $display("FAIL reset_pulses got %h/%h/%h want 0", bus_a.FlagErr, bus_a.SpuriousFlag, bus_a.AbortErr);
    end
    checks++;
    if (bus_a.ErrCnt !== 16'd0 || bus_a.FlagCnt !== 16'd0 || bus_b.ErrCnt !== 2'd0) begin
      errors++; $display("FAIL reset_counts got %0d/%0d/%0d want 0", bus_a.ErrCnt, bus_a.FlagCnt, bus_b.ErrCnt);
    end
    go_run();
    checks++;
    if (bus_a.FlagCnt !== 16'd0 || bus_a.ErrCnt !== 16'd0) begin
      errors++; $display("FAIL idle_run got flag=%0d err=%0d want 0", bus_a.FlagCnt, bus_a.ErrCnt);
    end
  endtask

  task automatic test_flag_ok();
    do_reset(); go_run();
    send_flag(4'b0001);
    checks++;
    if (bus_a.FlagCnt !== 16'd1) begin
      errors++; $display("FAIL flag_count got %0d want 1", bus_a.FlagCnt);
    end
    tick();
    bus_a.Rx_FlagDetect = 4'b0001;
    tick();
    bus_a.Rx_FlagDetect = '0;
    checks++;
    if (bus_a.FlagErr !== 4'h0 || bus_a.SpuriousFlag !== 4'h0) begin
      errors++; $display("FAIL flag_ok_pulse got ferr=%h spur=%h want 0", bus_a.FlagErr, bus_a.SpuriousFlag);
    end
    tick();
    checks++;
    if (bus_a.ErrCnt !== 16'd0 || bus_a.FlagCnt !== 16'd1) begin
      errors++; $display("FAIL flag_ok_counts got err=%0d flag=%0d want 0/1", bus_a.ErrCnt, bus_a.FlagCnt);
    end
  endtask

  task automatic test_flag_missing();
    do_reset(); go_run();
    send_flag(4'b0001);
    tick();
    checks++;
    if (bus_a.FlagErr !== 4'h0) begin
      errors++; $display("FAIL flag_err_early got %h want 0", bus_a.FlagErr);
    end
    tick();
    checks++;
    if (bus_a.FlagErr !== 4'b0001) begin
      errors++; $display("FAIL flag_err_pulse got %h want 1", bus_a.FlagErr);
    end
    tick();
    checks++;
    if (bus_a.FlagErr !== 4'h0 || bus_a.ErrCnt !== 16'd1) begin
      errors++; $display("FAIL flag_err_after got ferr=%h err=%0d want 0/1", bus_a.FlagErr, bus_a.ErrCnt);
    end
  endtask

  task automatic test_abort();
    int n_pulse;
    int at8;
    do_reset(); go_run();
    bus_a.Rx_ValidFrame = 4'b0001;
    // Run 0: indication at t+1 satisfies; run 1: none; run 2: only at t (too early)
    for (int run = 0; run < 3; run++) begin
      n_pulse = 0; at8 = 0;
      bus_a.Rx[0] = 1'b0;
      tick();
      for (int k = 1; k <= 10; k++) begin
        bus_a.Rx[0] = 1'b1;
        bus_a.Rx_AbortSignal[0] = (run == 0 && k == 8) || (run == 2 && k == 7);
        tick();
        n_pulse += int'(bus_a.AbortErr[0]);
        if (k == 8) at8 = int'(bus_a.AbortErr[0]);
      end
      bus_a.Rx_AbortSignal = '0;
      checks++;
      if (n_pulse != ((run == 0) ? 0 : 1) || at8 != ((run == 0) ? 0 : 1)) begin
        errors++; $display("FAIL abort_run%0d got pulses=%0d at_t1=%0d", run, n_pulse, at8);
      end
      checks++;
      if (bus_a.ErrCnt !== 16'(run)) begin
        errors++; $display("FAIL abort_cnt%0d got %0d want %0d", run, bus_a.ErrCnt, run);
      end
    end
  endtask

  task automatic test_spurious();
    do_reset(); go_run();
    bus_a.Rx_FlagDetect = 4'b0001;
    tick();
    bus_a.Rx_FlagDetect = '0;
    checks++;
    if (bus_a.SpuriousFlag !== 4'b0001) begin
      errors++; $display("FAIL spurious_pulse got %h want 1", bus_a.SpuriousFlag);
    end
    tick();
    checks++;
    if (bus_a.SpuriousFlag !== 4'h0 || bus_a.ErrCnt !== 16'd1) begin
      errors++; $display("FAIL spurious_after got spur=%h err=%0d want 0/1", bus_a.SpuriousFlag, bus_a.ErrCnt);
    end
    do_reset();
    enable = 1'b1;
    tick();
    bus_a.Rx_FlagDetect = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus_a.SpuriousFlag !== 4'h0) begin
        errors++; $display("FAIL spurious_sync got %h want 0", bus_a.SpuriousFlag);
      end
    end
    bus_a.Rx_FlagDetect = '0;
    tick();
    checks++;
    if (bus_a.ErrCnt !== 16'd0) begin
      errors++; $display("FAIL spurious_sync_cnt got %0d want 0", bus_a.ErrCnt);
    end
  endtask

  task automatic test_multi_channel();
    do_reset(); go_run();
    send_flag(4'b0101);
    checks++;
    if (bus_a.FlagCnt !== 16'd2) begin
      errors++; $display("FAIL multi_flagcnt got %0d want 2", bus_a.FlagCnt);
    end
    tick();
    bus_a.Rx_FlagDetect = 4'b0001;
    clear_cnt = 1'b1;
    tick();
    bus_a.Rx_FlagDetect = '0;
    clear_cnt = 1'b0;
    checks++;
    if (bus_a.FlagErr !== 4'b0100) begin
      errors++; $display("FAIL multi_flagerr got %b want 0100", bus_a.FlagErr);
    end
    checks++;
    if (bus_a.ErrCnt !== 16'd0 || bus_a.FlagCnt !== 16'd0) begin
      errors++; $display("FAIL clear_wins got err=%0d flag=%0d want 0/0", bus_a.ErrCnt, bus_a.FlagCnt);
    end
  endtask

  task automatic test_saturation();
    do_reset(); go_run();
    for (int k = 0; k < 5; k++) begin
      bus_a.Rx_FlagDetect = 4'b0001; tick();
      bus_a.Rx_FlagDetect = '0;      tick();
    end
    checks++;
    if (bus_b.ErrCnt !== 2'd3 || bus_a.ErrCnt !== 16'd5) begin
      errors++; $display("FAIL saturate got narrow=%0d wide=%0d want 3/5", bus_b.ErrCnt, bus_a.ErrCnt);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus_b.ErrCnt !== 2'd0 || bus_a.ErrCnt !== 16'd0) begin
      errors++; $display("FAIL async_reset got narrow=%0d wide=%0d want 0", bus_b.ErrCnt, bus_a.ErrCnt);
    end
    @(posedge clk); @(negedge clk);
    model_reset(); rst = 1'b1;
  endtask

  task automatic test_pending_drop();
    // Reset mid-check
    do_reset(); go_run();
    send_flag(4'b0001);
    tick();
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    model_reset(); rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus_a.FlagErr !== 4'h0 || bus_a.ErrCnt !== 16'd0) begin
        errors++; $display("FAIL rst_drop got ferr=%h err=%0d want 0", bus_a.FlagErr, bus_a.ErrCnt);
      end
    end
    // Enable low mid-check
    do_reset(); go_run();
    send_flag(4'b0001);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus_a.FlagErr !== 4'h0) begin
        errors++; $display("FAIL en_drop got ferr=%h want 0", bus_a.FlagErr);
      end
    end
    checks++;
    if (bus_a.ErrCnt !== 16'd0 || bus_a.FlagCnt !== 16'd1) begin
      errors++; $display("FAIL en_drop_cnt got err=%0d flag=%0d want 0/1", bus_a.ErrCnt, bus_a.FlagCnt);
    end
  endtask

  task automatic refill(input int ch);
    logic [7:0] fl;
    int k, n;
    fl = 8'h7E;
    k = $urandom_range(0, 4);
    case (k)
      0: for (int i = 0; i < 8; i++) src[ch].push_back(fl[7-i]);
      1: begin
        src[ch].push_back(1'b0);
        n = $urandom_range(5, 11);
        repeat (n) src[ch].push_back(1'b1);
      end
      2: begin
        n = $urandom_range(1, 6);
        repeat (n) src[ch].push_back(1'($urandom_range(0, 1)));
      end
      3: for (int f = 0; f < 2; f++) begin
        for (int i = 0; i < 7; i++) src[ch].push_back(fl[7-i]);
        if (f == 1) src[ch].push_back(1'b0);
      end
      default: begin
        n = $urandom_range(1, 4);
        repeat (n) src[ch].push_back(1'b1);
      end
    endcase
  endtask

  task automatic test_random();
    logic [NCH-1:0] rxv, fdv, abv;
    int shown;
    shown = 0;
    do_reset();
    enable = 1'b1;
    for (int t = 0; t < 4000; t++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (src[ch].size() == 0) refill(ch);
        rxv[ch] = src[ch].pop_front();
        if ($urandom_range(0, 15) == 0) bus_a.Rx_ValidFrame[ch] = ~bus_a.Rx_ValidFrame[ch];
        fdv[ch] = (due[ch].size() > 0 && due[ch][0] == cyc + 1) ? ($urandom_range(0, 5) != 0)
                                                                 : ($urandom_range(0, 49) == 0);
        abv[ch] = (abort_dl[ch] >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 59) == 0);
      end
      bus_a.Rx = rxv; bus_a.Rx_FlagDetect = fdv; bus_a.Rx_AbortSignal = abv;
      enable    = ($urandom_range(0, 249) != 0);
      clear_cnt = ($urandom_range(0, 199) == 0);
      tick();
      checks += 8;
      if (bus_a.FlagErr !== e_ferr || bus_a.SpuriousFlag !== e_spur || bus_a.AbortErr !== e_aerr ||
          bus_a.ErrCnt !== 16'(e_err) || bus_a.FlagCnt !== 16'(e_flag) ||
          bus_b.ErrCnt !== 2'(e_err2) || bus_b.FlagCnt !== 2'(e_flag2) || bus_b.FlagErr !== e_ferr[0]) begin
        errors++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random cyc=%0d got ferr=%h spur=%h aerr=%h err=%0d flag=%0d b_err=%0d b_flag=%0d want %h %h %h %0d %0d %0d %0d",
                   cyc, bus_a.FlagErr, bus_a.SpuriousFlag, bus_a.AbortErr, bus_a.ErrCnt, bus_a.FlagCnt,
                   bus_b.ErrCnt, bus_b.FlagCnt, e_ferr, e_spur, e_aerr, e_err, e_flag, e_err2, e_flag2);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    enable = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_flag_ok();
    test_flag_missing();
    test_abort();
    test_spurious();
    test_multi_channel();
    test_saturation();
    test_pending_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
